lc3_mem_responder: RTL and testbench

- Memory-side responder for the LC3 datapath's memory port. It is the slave end of the interface that drives MAR/MDR.
- Accepts one read or write request at a time from the CPU and applies a programmable number of wait states.
- Returns read data and a one-cycle ready pulse. The CPU's memory FSM stalls on this pulse.
- Backed by an internal word-addressed RAM with a bounded depth. Out-of-range accesses are flagged, never aliased.

---
 rtl/lc3_mem_responder.sv | 128 ++++++++++++
 tb/tb_lc3_mem_responder.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lc3_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : lc3_mem_responder
// Brief    : Memory-side responder for the LC3 MAR/MDR port: programmable
//            wait states, word RAM, out-of-range error flag.
// Revision : 1.0 - initial release
// ============================================================================
module lc3_mem_responder #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 16,
    parameter int DEPTH_LOG2 = 10,
    parameter int WAIT_MAX   = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_en,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [2:0]        wait_cfg,
    output logic [DATA_W-1:0] rdata,
    output logic              mem_rdy,
    output logic              mem_err,
    output logic              busy
);

    localparam int         c_depth    = 1 << DEPTH_LOG2;
    localparam logic [2:0] c_wait_max = (WAIT_MAX > 7) ? 3'd7 : 3'(WAIT_MAX);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_next;
    logic [2:0]              r_cnt;
    logic [2:0]              w_cnt_next;
    logic [DEPTH_LOG2-1:0]   r_addr;
    logic                    r_we;
    logic                    r_oor;
    logic [DATA_W-1:0]       r_wdata;
    logic [DATA_W-1:0]       r_rdata;
    logic [DATA_W-1:0]       r_mem [c_depth];

    logic [2:0]              w_wait;
    logic                    w_accept;
    logic                    w_oor_in;
    logic                    w_enter_resp;
    logic [DEPTH_LOG2-1:0]   w_rd_addr;
    logic                    w_rd_we;
    logic                    w_rd_oor;

    assign w_wait   = (wait_cfg > c_wait_max) ? c_wait_max : wait_cfg;
    assign w_accept = (r_state == ST_IDLE) && mem_en;
    assign w_oor_in = (addr >> DEPTH_LOG2) != '0;

    // A zero-wait access enters RESP straight from IDLE, so the read must use
    // the live request; otherwise the latched copy is used.
    assign w_enter_resp = (w_next == ST_RESP) && (r_state != ST_RESP);
    assign w_rd_addr    = (r_state == ST_IDLE) ? addr[DEPTH_LOG2-1:0] : r_addr;
    assign w_rd_we      = (r_state == ST_IDLE) ? mem_we : r_we;
    assign w_rd_oor     = (r_state == ST_IDLE) ? w_oor_in : r_oor;

    always_comb begin
        w_next     = r_state;
        w_cnt_next = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (mem_en) begin
                    w_cnt_next = w_wait;
                    w_next     = (w_wait != 3'd0) ? ST_WAIT : ST_RESP;
                end
            end
            ST_WAIT: begin
                w_cnt_next = r_cnt - 3'd1;
                if (r_cnt <= 3'd1) begin
                    w_next = ST_RESP;
                end
            end
            ST_RESP: begin
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= 3'd0;
            r_addr  <= '0;
            r_we    <= 1'b0;
            r_oor   <= 1'b0;
            r_wdata <= '0;
            r_rdata <= '0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
            if (w_accept) begin
                r_addr  <= addr[DEPTH_LOG2-1:0];
                r_we    <= mem_we;
                r_oor   <= w_oor_in;
                r_wdata <= wdata;
            end
            if (w_enter_resp && !w_rd_we) begin
                r_rdata <= w_rd_oor ? '0 : r_mem[w_rd_addr];
            end
        end
    end

    // Reset forces the state out of RESP asynchronously, which blocks the write.
    always_ff @(posedge clk) begin
        if ((r_state == ST_RESP) && r_we && !r_oor) begin
            r_mem[r_addr] <= r_wdata;
        end
    end

    assign rdata   = r_rdata;
    assign mem_rdy = (r_state == ST_RESP);
    assign mem_err = (r_state == ST_RESP) && r_oor;
    assign busy    = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_lc3_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_lc3_mem_responder
// Brief    : Self-checking bench for lc3_mem_responder against a word-map model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lc3_mem_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        mem_en = 1'b0;
    logic        mem_we = 1'b0;
    logic [15:0] addr = 16'h0;
    logic [15:0] wdata = 16'h0;
    logic [2:0]  wait_cfg = 3'd0;
    logic [15:0] rdata;
    logic        mem_rdy;
    logic        mem_err;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;

    logic [15:0] model [int];
    logic [15:0] exp_rdata = 16'h0;

    lc3_mem_responder #(
        .ADDR_W(16), .DATA_W(16), .DEPTH_LOG2(10), .WAIT_MAX(7)
    ) dut (
        .clk(clk), .rst(rst), .mem_en(mem_en), .mem_we(mem_we),
        .addr(addr), .wdata(wdata), .wait_cfg(wait_cfg),
        .rdata(rdata), .mem_rdy(mem_rdy), .mem_err(mem_err), .busy(busy)
    );

    always #5 clk = ~clk;

    // One access; inputs are scrambled right after acceptance.
    task automatic access(input logic we, input logic [15:0] a, input logic [15:0] d,
                          input logic [2:0] w, output int lat, output logic [15:0] rd,
                          output logic err, output logic proto_ok);
        @(negedge clk);
        mem_en = 1'b1; mem_we = we; addr = a; wdata = d; wait_cfg = w;
        @(negedge clk);
        mem_en = 1'b0; mem_we = 1'($urandom); addr = 16'($urandom);
        wdata = 16'($urandom); wait_cfg = 3'($urandom);
        lat = 1;
        proto_ok = busy;
        while (!mem_rdy && lat < 20) begin
            if (mem_err) proto_ok = 1'b0;
            @(negedge clk);
            lat++;
        end
        rd  = rdata;
        err = mem_err;
        @(negedge clk);
        if (busy || mem_rdy || mem_err) proto_ok = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        n_tests++;
        if ({rdata, mem_rdy, mem_err, busy} !== 19'h0) begin
            n_fail++;
            $display("FAIL reset_state: got rdata=%h rdy=%b err=%b busy=%b required all 0",
                     rdata, mem_rdy, mem_err, busy);
        end
        rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n_tests++;
            if ({rdata, mem_rdy, mem_err, busy} !== 19'h0) begin
                n_fail++;
                $display("FAIL reset_idle[%0d]: got rdata=%h rdy=%b err=%b busy=%b required all 0",
                         i, rdata, mem_rdy, mem_err, busy);
            end
        end
        exp_rdata = 16'h0;
    endtask

    task automatic test_zero_wait();
        int lat; logic [15:0] rd; logic err; logic ok;
        access(1'b1, 16'h0005, 16'hBEEF, 3'd0, lat, rd, err, ok);
        model[5] = 16'hBEEF;
        n_tests++;
        if (lat !== 1 || err !== 1'b0 || ok !== 1'b1 || rd !== exp_rdata) begin
            n_fail++;
            $display("FAIL zero_wait_write: got lat=%0d err=%b proto=%b rdata=%h required 1 0 1 %h",
                     lat, err, ok, rd, exp_rdata);
        end
        access(1'b0, 16'h0005, 16'h0000, 3'd0, lat, rd, err, ok);
        exp_rdata = 16'hBEEF;
        n_tests++;
        if (lat !== 1 || err !== 1'b0 || ok !== 1'b1 || rd !== 16'hBEEF) begin
            n_fail++;
            $display("FAIL zero_wait_read: got lat=%0d err=%b proto=%b rdata=%h required 1 0 1 beef",
                     lat, err, ok, rd);
        end
    endtask

    task automatic test_wait_states();
        int lat; logic [15:0] rd; logic err; logic ok;
        for (int w = 1; w <= 7; w += 2) begin
            access(1'b0, 16'h0005, 16'h0000, 3'(w), lat, rd, err, ok);
            n_tests++;
            if (lat !== w + 1 || err !== 1'b0 || ok !== 1'b1 || rd !== 16'hBEEF) begin
                n_fail++;
                $display("FAIL wait_states[%0d]: got lat=%0d err=%b proto=%b rdata=%h required %0d 0 1 beef",
                         w, lat, err, ok, rd, w + 1);
            end
        end
    endtask

    task automatic test_out_of_range();
        int lat; logic [15:0] rd; logic err; logic ok;
        access(1'b1, 16'h0000, 16'h5A5A, 3'd0, lat, rd, err, ok);
        model[0] = 16'h5A5A;
        access(1'b1, 16'h0400, 16'h1234, 3'd0, lat, rd, err, ok);
        n_tests++;
        if (lat !== 1 || err !== 1'b1 || ok !== 1'b1) begin
            n_fail++;
            $display("FAIL oor_write: got lat=%0d err=%b proto=%b required 1 1 1", lat, err, ok);
        end
        access(1'b0, 16'h0000, 16'h0000, 3'd1, lat, rd, err, ok);
        exp_rdata = 16'h5A5A;
        n_tests++;
        if (rd !== 16'h5A5A || err !== 1'b0 || lat !== 2) begin
            n_fail++;
            $display("FAIL oor_no_alias: got rdata=%h err=%b lat=%0d required 5a5a 0 2", rd, err, lat);
        end
        access(1'b0, 16'h0400, 16'h0000, 3'd2, lat, rd, err, ok);
        exp_rdata = 16'h0000;
        n_tests++;
        if (rd !== 16'h0000 || err !== 1'b1 || lat !== 3 || ok !== 1'b1) begin
            n_fail++;
            $display("FAIL oor_read: got rdata=%h err=%b lat=%0d proto=%b required 0000 1 3 1",
                     rd, err, lat, ok);
        end
        access(1'b1, 16'h03FF, 16'hC0DE, 3'd0, lat, rd, err, ok);
        model[16'h3FF] = 16'hC0DE;
        access(1'b0, 16'h03FF, 16'h0000, 3'd0, lat, rd, err, ok);
        exp_rdata = 16'hC0DE;
        n_tests++;
        if (rd !== 16'hC0DE || err !== 1'b0) begin
            n_fail++;
            $display("FAIL top_word: got rdata=%h err=%b required c0de 0", rd, err);
        end
    endtask

    task automatic test_random();
        int lat; logic [15:0] rd; logic err; logic ok;
        logic [15:0] a; logic [15:0] d; logic we; logic [2:0] w; logic oor;
        for (int i = 0; i < 8; i++) begin
            a = (i < 4) ? 16'(i) : 16'(16'h03F8 + i);
            d = 16'($urandom);
            access(1'b1, a, d, 3'd0, lat, rd, err, ok);
            model[int'(a)] = d;
        end
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 7) == 0) a = 16'($urandom_range(16'h0400, 16'hFFFF));
            else if ($urandom_range(0, 1) == 0) a = 16'($urandom_range(0, 3));
            else a = 16'($urandom_range(16'h03FC, 16'h03FF));
            d   = 16'($urandom);
            we  = 1'($urandom);
            w   = 3'($urandom);
            oor = (a >= 16'h0400);
            access(we, a, d, w, lat, rd, err, ok);
            n_tests++;
            if (lat !== int'(w) + 1 || err !== oor || ok !== 1'b1) begin
                n_fail++;
                $display("FAIL rand_proto[%0d]: got lat=%0d err=%b proto=%b required %0d %b 1",
                         i, lat, err, ok, int'(w) + 1, oor);
            end
            if (!we) exp_rdata = oor ? 16'h0000 : model[int'(a)];
            if (!(we && oor)) begin
                n_tests++;
                if (rd !== exp_rdata) begin
                    n_fail++;
                    $display("FAIL rand_rdata[%0d]: we=%b addr=%h got %h required %h",
                             i, we, a, rd, exp_rdata);
                end
            end
            if (we && !oor) model[int'(a)] = d;
        end
    endtask

    task automatic test_back_to_back();
        int  rdy_cnt = 0;
        int  adjacent = 0;
        logic prev = 1'b0;
        @(negedge clk);
        mem_en = 1'b1; mem_we = 1'b0; addr = 16'h0005; wait_cfg = 3'd0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (mem_rdy) rdy_cnt++;
            if (mem_rdy && prev) adjacent++;
            prev = mem_rdy;
        end
        mem_en = 1'b0;
        @(negedge clk);
        @(negedge clk);
        exp_rdata = 16'hBEEF;
        n_tests++;
        if (rdy_cnt !== 6 || adjacent !== 0 || rdata !== 16'hBEEF) begin
            n_fail++;
            $display("FAIL back_to_back: got pulses=%0d adjacent=%0d rdata=%h required 6 0 beef",
                     rdy_cnt, adjacent, rdata);
        end
    endtask

    task automatic test_busy_drop();
        int lat; logic [15:0] rd; logic err; logic ok;
        int rdy_cnt = 0;
        @(negedge clk);
        mem_en = 1'b1; mem_we = 1'b0; addr = 16'h0005; wait_cfg = 3'd5;
        @(negedge clk);
        mem_en = 1'b0;
        if (mem_rdy) rdy_cnt++;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            if (i == 1) begin
                mem_en = 1'b1; mem_we = 1'b1; addr = 16'h0005; wdata = 16'h0BAD; wait_cfg = 3'd0;
            end else begin
                mem_en = 1'b0;
            end
            if (mem_rdy) rdy_cnt++;
        end
        n_tests++;
        if (rdy_cnt !== 1 || rdata !== 16'hBEEF) begin
            n_fail++;
            $display("FAIL busy_drop_pulses: got pulses=%0d rdata=%h required 1 beef", rdy_cnt, rdata);
        end
        access(1'b0, 16'h0005, 16'h0000, 3'd0, lat, rd, err, ok);
        n_tests++;
        if (rd !== model[5]) begin
            n_fail++;
            $display("FAIL busy_drop_word: got %h required %h", rd, model[5]);
        end
        exp_rdata = model[5];
    endtask

    task automatic test_reset_mid();
        int lat; logic [15:0] rd; logic err; logic ok;
        int rdy_cnt = 0;
        access(1'b1, 16'h0010, 16'h1111, 3'd0, lat, rd, err, ok);
        model[16'h10] = 16'h1111;
        @(negedge clk);
        mem_en = 1'b1; mem_we = 1'b1; addr = 16'h0010; wdata = 16'hAAAA; wait_cfg = 3'd4;
        @(negedge clk);
        mem_en = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (mem_rdy || busy) rdy_cnt++;
        end
        n_tests++;
        if (rdy_cnt !== 0 || rdata !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_wait: got active_cycles=%0d rdata=%h required 0 0000", rdy_cnt, rdata);
        end
        @(negedge clk);
        mem_en = 1'b1; mem_we = 1'b1; addr = 16'h0010; wdata = 16'hBBBB; wait_cfg = 3'd0;
        @(negedge clk);
        mem_en = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        access(1'b0, 16'h0010, 16'h0000, 3'd0, lat, rd, err, ok);
        n_tests++;
        if (rd !== 16'h1111 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_no_write: got rdata=%h err=%b required 1111 0", rd, err);
        end
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_wait_states();
        test_out_of_range();
        test_random();
        test_back_to_back();
        test_busy_drop();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
